// File: rtl/usb_dec_pkg.sv
// Shared encodings, state type and default windows for the USB slave address decoder.
package usb_dec_pkg;

  localparam logic [1:0]  OP_WR         = 2'b10;
  localparam logic [1:0]  OP_RD         = 2'b01;
  localparam logic [31:0] MEM_BASE_DFLT = 32'h0000_0000;
  localparam logic [31:0] REG_BASE_DFLT = 32'h0000_0400;
  localparam int          CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dec_state_e;

endpackage

// File: rtl/usb_dec_region_match.sv
// Window hit and word-index extraction for one aligned address window.
module usb_dec_region_match #(
  parameter int                ADDR_W = 32,
  parameter int                AW     = 8,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input  logic [ADDR_W-3:0] word_addr,
  output logic              hit,
  output logic [AW-1:0]     idx
);

  localparam logic [ADDR_W-3:0] BASE_WORD = BASE[ADDR_W-1:2];

  assign hit = (word_addr[ADDR_W-3:AW] == BASE_WORD[ADDR_W-3:AW]);
  assign idx = word_addr[AW-1:0] - BASE_WORD[AW-1:0];

endmodule

// File: rtl/usb_addr_decoder.sv
// Single-outstanding request decoder: strobes memory or register target, then returns a response.
//   state | meaning
//   IDLE  | req_ready high, waiting for a request
//   WAIT  | read latency counter running
//   RESP  | rsp_valid high until rsp_ready
module usb_addr_decoder
  import usb_dec_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                MEM_AW   = 8,
  parameter int                REG_AW   = 6,
  parameter logic [ADDR_W-1:0] MEM_BASE = ADDR_W'(MEM_BASE_DFLT),
  parameter logic [ADDR_W-1:0] REG_BASE = ADDR_W'(REG_BASE_DFLT),
  parameter int unsigned       RD_LAT   = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              reg_en,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_addr,
  output logic              rd_en_reg,
  output logic              data_toggle_en,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_err
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT);

  dec_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_rd_q, mem_rd_d;

  logic              mem_hit, reg_hit;
  logic [MEM_AW-1:0] mem_idx;
  logic [REG_AW-1:0] reg_idx;
  logic              is_rd, op_ok, req_err, sel_mem, sel_reg, accept;

  logic              req_ready_d, mem_en_d, mem_we_d, reg_en_d, reg_we_d;
  logic              rd_en_reg_d, toggle_d, rsp_valid_d, rsp_err_d;
  logic [MEM_AW-1:0] mem_addr_d;
  logic [REG_AW-1:0] reg_addr_d;

  usb_dec_region_match #(
    .ADDR_W (ADDR_W),
    .AW     (MEM_AW),
    .BASE   (MEM_BASE)
  ) u_mem_match (
    .word_addr (req_addr[ADDR_W-1:2]),
    .hit       (mem_hit),
    .idx       (mem_idx)
  );

  usb_dec_region_match #(
    .ADDR_W (ADDR_W),
    .AW     (REG_AW),
    .BASE   (REG_BASE)
  ) u_reg_match (
    .word_addr (req_addr[ADDR_W-1:2]),
    .hit       (reg_hit),
    .idx       (reg_idx)
  );

  // Memory window takes priority when the two windows overlap.
  assign is_rd   = (req_op == OP_RD);
  assign op_ok   = (req_op == OP_RD) || (req_op == OP_WR);
  assign req_err = !op_ok || (req_addr[1:0] != 2'b00) || !(mem_hit || reg_hit);
  assign sel_mem = !req_err && mem_hit;
  assign sel_reg = !req_err && !mem_hit && reg_hit;
  assign accept  = (state_q == IDLE) && req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_rd_d    = mem_rd_q;
    req_ready_d = req_ready;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    reg_en_d    = 1'b0;
    reg_we_d    = 1'b0;
    rd_en_reg_d = 1'b0;
    toggle_d    = 1'b0;
    rsp_valid_d = rsp_valid;
    rsp_err_d   = rsp_err;
    mem_addr_d  = mem_addr;
    reg_addr_d  = reg_addr;

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          req_ready_d = 1'b0;
          mem_rd_d    = sel_mem && is_rd;
          mem_en_d    = sel_mem;
          mem_we_d    = sel_mem && !is_rd;
          reg_en_d    = sel_reg;
          reg_we_d    = sel_reg && !is_rd;
          rd_en_reg_d = sel_reg && is_rd;
          if (sel_mem) mem_addr_d = mem_idx;
          if (sel_reg) reg_addr_d = reg_idx;
          cnt_d = (!req_err && is_rd) ? LAT_LOAD : '0;
          if (cnt_d == '0) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_err;
            toggle_d    = sel_mem && is_rd;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        // Only good reads ever wait, so the response here is never an error.
        if (cnt_q <= 1) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          toggle_d    = mem_rd_q;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      mem_rd_q       <= 1'b0;
      req_ready      <= 1'b0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      reg_en         <= 1'b0;
      reg_we         <= 1'b0;
      reg_addr       <= '0;
      rd_en_reg      <= 1'b0;
      data_toggle_en <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_err        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mem_rd_q       <= mem_rd_d;
      req_ready      <= req_ready_d;
      mem_en         <= mem_en_d;
      mem_we         <= mem_we_d;
      mem_addr       <= mem_addr_d;
      reg_en         <= reg_en_d;
      reg_we         <= reg_we_d;
      reg_addr       <= reg_addr_d;
      rd_en_reg      <= rd_en_reg_d;
      data_toggle_en <= toggle_d;
      rsp_valid      <= rsp_valid_d;
      rsp_err        <= rsp_err_d;
    end
  end

endmodule

// File: doc/usb_addr_decoder.md
# usb_addr_decoder

Parametrised address decoder and access sequencer for the AXI-to-USB slave. It accepts one bus request at a time over a valid/ready handshake and decodes it against a memory window and a register window. It issues a one-cycle strobe to the selected target, waits a configurable read latency, and returns a response with an error flag. It sits between the AXI slave front-end and the USB packet memory and register file, and drives the data-toggle enable for memory reads.

## Interface
- ADDR_W, 32, request address width
- MEM_AW, 8, memory word-address width; memory window is 2^(MEM_AW+2) bytes
- REG_AW, 6, register word-address width; register window is 2^(REG_AW+2) bytes
- MEM_BASE, 32'h0000_0000, byte base of the memory window; aligned to the window size
- REG_BASE, 32'h0000_0400, byte base of the register window; aligned to the window size
- RD_LAT, 1, cycles from read strobe to read data valid; range 0..15
- Clk  in  1  clock
- Rst  in  1  reset; asynchronous assert, active-low
- req_valid  in  1  request present
- req_ready  out  1  decoder can accept a request
- req_op  in  2  operation: 2'b10 = write (bus to USB), 2'b01 = read (USB to bus); 00/11 are illegal
- req_addr  in  ADDR_W  byte address
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write qualifier
- mem_addr  out  MEM_AW  memory word index, req_addr[MEM_AW+1:2] − MEM_BASE word offset
- reg_en  out  1  register access strobe
- reg_we  out  1  register write qualifier
- reg_addr  out  REG_AW  register word index, same rule as mem_addr
- rd_en_reg  out  1  register read enable; equals reg_en & ~reg_we
- data_toggle_en  out  1  data-toggle update pulse
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_err  out  1  response is an error

## Operation
- States:
  - IDLE: req_ready=1.
  - WAIT: latency counter running.
  - RESP: rsp_valid=1 until rsp_ready.
- Acceptance: req_valid & req_ready sampled at edge T.
  - Decode, latch the op, indices and error.
  - Load the counter: RD_LAT for a good read, 0 otherwise.
  - Go to WAIT, or straight to RESP when the loaded count is 0.
- Decode rules:
  - Memory hit when req_addr[ADDR_W-1:MEM_AW+2] equals the same bits of MEM_BASE; register hit uses the same rule with REG_AW/REG_BASE.
  - If both windows hit, memory wins.
- Errors: no hit, req_addr[1:0]≠0, or illegal op.
  - No strobe is issued; rsp_err=1.
- WAIT decrements the counter each cycle and enters RESP on the cycle the counter reaches 0.
- RESP leaves to IDLE on the edge where rsp_valid & rsp_ready.
- rsp_err holds its value while rsp_valid=1.
- data_toggle_en: single-cycle pulse in the first RESP cycle of a non-error memory read only; never on writes, register reads or errors.
- Index outputs hold their last value when their strobe is low.
- Reset: all outputs 0, including req_ready; state IDLE; counter 0. req_ready rises in the first cycle after Rst deasserts.
- Reset mid-operation aborts the transaction. No response is produced afterwards.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- A strobe (mem_en/reg_en, with qualifiers and index) is high for exactly one cycle, T+1.
- rsp_valid first rises:
  - write or error: T+1
  - read: T+1+RD_LAT
- req_ready is low from T+1 until the cycle after the response handshake.
- Minimum request-to-request spacing: 2 cycles for write or error, 2+RD_LAT cycles for read.
- Requests are not pipelined; req_valid while req_ready=0 is held by the source and is not sampled.
- Changing req_* while req_valid=1 and req_ready=0 is legal.

## Structure
- Package usb_dec_pkg holds:
  - op encodings OP_WR=2'b10 and OP_RD=2'b01
  - state enum {IDLE, WAIT, RESP}
  - default MEM_BASE and REG_BASE
- Sub-module usb_dec_region_match (parameters BASE, AW): purely combinational window hit plus word-index extraction. Instantiated twice.
- Counter width is 4 bits.

## Test plan
- Write 0x0000_0010 (defaults) -> mem_en=1, mem_we=1, mem_addr=0x04 at T+1; rsp_valid at T+1 with rsp_err=0; no data_toggle_en.
- Read 0x0000_0404, RD_LAT=3 -> reg_en=1, rd_en_reg=1, reg_addr=0x01 at T+1; rsp_valid at T+4; data_toggle_en stays 0.
- Read 0x0000_03FC, RD_LAT=0 -> mem_addr=0xFF at T+1; rsp_valid and a one-cycle data_toggle_en at T+1; hold rsp_ready=0 for 3 cycles -> rsp_valid stays high, no second toggle pulse.
- Errors, each -> no strobe; rsp_valid=1, rsp_err=1 at T+1:
  - read 0x0000_0802
  - write 0x0000_0800
  - req_op=2'b11
- Reset:
  - Rst low during WAIT of an RD_LAT=5 read -> all outputs 0 immediately; req_ready=1 one cycle after release; no stale rsp_valid.
  - Back-to-back write/read with rsp_ready always 1 -> second request accepted no earlier than 2 cycles after the first.
